// File: rtl/sdl_video_pipe.sv
`default_nettype none
// ============================================================================
// Module  : sdl_video_pipe
// Brief   : Raster timing generator with coordinate/sync alignment to a
//           pipelined colour source and a registered, blanked SDL pixel output.
// Rev     : 1.0  initial release
// ============================================================================
module sdl_video_pipe #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 4,
  parameter int LATENCY  = 0
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  output logic [10:0]        h_coord,
  output logic [9:0]         v_coord,
  input  logic [COLOR_W-1:0] red,
  input  logic [COLOR_W-1:0] green,
  input  logic [COLOR_W-1:0] blue,
  output logic [10:0]        sdl_sx,
  output logic [9:0]         sdl_sy,
  output logic               sdl_de,
  output logic [7:0]         sdl_r,
  output logic [7:0]         sdl_g,
  output logic [7:0]         sdl_b,
  output logic               h_sync,
  output logic               v_sync,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_DE_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_DE_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word: {sx, sy, de, hs, vs}; all-zero is the idle/blank word.
  localparam int PIPE_W = 11 + 10 + 3;

  logic              h_last;
  logic              v_last;
  logic              frame_wrap;
  logic              src_de;
  logic              src_hs;
  logic              src_vs;
  logic [PIPE_W-1:0] src_bus;
  logic [PIPE_W-1:0] dly_bus;
  logic [10:0]       dly_sx;
  logic [9:0]        dly_sy;
  logic              dly_de;
  logic              dly_hs;
  logic              dly_vs;

  assign h_last     = (h_coord == H_LAST);
  assign v_last     = (v_coord == V_LAST);
  assign frame_wrap = h_last && v_last;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_coord     <= '0;
      v_coord     <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (h_last) begin
        h_coord <= '0;
        if (v_last) begin
          v_coord <= '0;
        end else begin
          v_coord <= v_coord + 10'd1;
        end
      end else begin
        h_coord <= h_coord + 11'd1;
      end
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign src_de  = (h_coord < H_DE_END) && (v_coord < V_DE_END);
  assign src_hs  = (h_coord >= HS_START) && (h_coord < HS_END);
  assign src_vs  = (v_coord >= VS_START) && (v_coord < VS_END);
  assign src_bus = {h_coord, v_coord, src_de, src_hs, src_vs};

  generate
    if (LATENCY == 0) begin : g_no_delay
      assign dly_bus = src_bus;
    end else begin : g_delay
      logic [PIPE_W-1:0] stage [LATENCY];

      always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= src_bus;
          for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dly_bus = stage[LATENCY-1];
    end
  endgenerate

  assign {dly_sx, dly_sy, dly_de, dly_hs, dly_vs} = dly_bus;

  // MSB-first replication of the channel value, truncated to 8 bits.
  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[7-i] = c[COLOR_W-1-(i % COLOR_W)];
    end
    return o;
  endfunction

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sdl_sx <= '0;
      sdl_sy <= '0;
      sdl_de <= 1'b0;
      sdl_r  <= '0;
      sdl_g  <= '0;
      sdl_b  <= '0;
      h_sync <= ~HS_POL;
      v_sync <= ~VS_POL;
    end else begin
      sdl_sx <= dly_sx;
      sdl_sy <= dly_sy;
      sdl_de <= dly_de;
      sdl_r  <= dly_de ? expand(red)   : 8'h00;
      sdl_g  <= dly_de ? expand(green) : 8'h00;
      sdl_b  <= dly_de ? expand(blue)  : 8'h00;
      h_sync <= dly_hs ? HS_POL : ~HS_POL;
      v_sync <= dly_vs ? VS_POL : ~VS_POL;
    end
  end

endmodule
`default_nettype wire
